// File: rtl/codec_adc_rx.sv
// codec_adc_rx: I2S ADC receiver, first stage of the pedal chain.
// Oversamples the codec pins in the Clk domain (BCLK is never used as a clock),
// deserialises one channel MSB-first and offers the word downstream with a
// level Start/Done handshake.
//
// Ports
//   Clk, Reset_n    system clock, asynchronous active-low reset
//   AUD_BCLK        codec bit clock (async, sampled)
//   AUD_ADCLRCK     codec frame clock (async, sampled); low = left
//   AUD_ADCDAT      codec serial data, MSB first (async, sampled)
//   Done            downstream has consumed Sample_out (level)
//   Sample_out      captured word, stable while Start = 1
//   Start           word pending for downstream (level)
//   Overrun         1-cycle pulse when a completed word is dropped
module codec_adc_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CHANNEL     = 0
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  input  logic                  Done,
  output logic [DATA_WIDTH-1:0] Sample_out,
  output logic                  Start,
  output logic                  Overrun
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SKIP, SHIFT, COMMIT, HOLD} state_t;

  // Synchronisers, one row per pin: [0] BCLK, [1] LRCK, [2] DAT.
  logic [2:0]                  pins;
  logic [2:0][SYNC_STAGES-1:0] sync_q;
  logic                        bclk_s, lrck_s, dat_s;
  logic                        bclk_d, lrck_d;
  logic                        bclk_rise, lr_edge, lr_enter;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q;
  logic [CW-1:0]         cnt_q;
  logic                  skip_take, shift_en, commit;

  assign pins = {AUD_ADCDAT, AUD_ADCLRCK, AUD_BCLK};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
      bclk_d <= 1'b0;
      lrck_d <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pins[i]};
      bclk_d <= bclk_s;
      lrck_d <= lrck_s;
    end
  end

  // DAT is taken from the same depth as BCLK so a rise sees the bit it clocks.
  assign bclk_s    = sync_q[0][SYNC_STAGES-1];
  assign lrck_s    = sync_q[1][SYNC_STAGES-1];
  assign dat_s     = sync_q[2][SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_d;
  assign lr_edge   = lrck_s ^ lrck_d;
  assign lr_enter  = lr_edge && (lrck_s == CHANNEL[0]);

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state. Any frame edge outside IDLE drops back to IDLE and is
  // re-evaluated in the same cycle, so a short frame or the end of a long
  // slot never costs us the following word.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (lr_enter) state_d = SKIP;
      SKIP:   if (lr_edge)        state_d = lr_enter ? SKIP : IDLE;
              else if (bclk_rise) state_d = SHIFT;
      SHIFT:  if (lr_edge) state_d = lr_enter ? SKIP : IDLE;
              else if (bclk_rise && cnt_q == CW'(DATA_WIDTH - 1)) state_d = COMMIT;
      COMMIT: if (lr_edge) state_d = lr_enter ? SKIP : IDLE;
              else         state_d = HOLD;
      HOLD:   if (lr_edge) state_d = lr_enter ? SKIP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State decode
  always_comb begin
    skip_take = (state_q == SKIP)  && bclk_rise && !lr_edge;
    shift_en  = (state_q == SHIFT) && bclk_rise && !lr_edge;
    commit    = (state_q == COMMIT);
  end

  // Datapath and handshake
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      Sample_out <= '0;
      Start      <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      Overrun <= 1'b0;
      if (skip_take) cnt_q <= '0;
      if (shift_en) begin
        sr_q  <= {sr_q[DATA_WIDTH-2:0], dat_s};
        cnt_q <= cnt_q + CW'(1);
      end
      if (Start && Done) Start <= 1'b0;
      // A still-high Done blocks acceptance so a stale level cannot
      // immediately retire the new word.
      if (commit) begin
        if (!Start && !Done) begin
          Sample_out <= sr_q;
          Start      <= 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_codec_adc_rx.sv
module tb_codec_adc_rx;
  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT;
  logic        Done0, Done1;
  logic [15:0] Sample0, Sample1;
  logic        Start0, Start1, Overrun0, Overrun1;

  logic [15:0] q0[$], q1[$];
  int          n_chk = 0, n_pass = 0;
  int          ov0 = 0, ov1 = 0;
  bit          hold0 = 1'b0;

  always #5 Clk = ~Clk;

  codec_adc_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2), .CHANNEL(0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_ADCDAT(AUD_ADCDAT), .Done(Done0), .Sample_out(Sample0), .Start(Start0),
    .Overrun(Overrun0));

  codec_adc_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2), .CHANNEL(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_ADCDAT(AUD_ADCDAT), .Done(Done1), .Sample_out(Sample1), .Start(Start1),
    .Overrun(Overrun1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One BCLK period (8 Clk): data and LRCK change while BCLK is low.
  task automatic bitp(input logic lr, input logic d);
    AUD_BCLK = 1'b0; AUD_ADCLRCK = lr; AUD_ADCDAT = d;
    repeat (4) @(negedge Clk);
    AUD_BCLK = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  // One I2S slot: delay bit, nw word bits MSB first, ntr trailing bits.
  // rst_at >= 0 pulses Reset_n just before that word bit.
  task automatic slot(input logic lr, input logic [15:0] w, input int nw,
                      input int ntr, input logic tv, input int rst_at);
    bitp(lr, 1'b0);
    for (int i = 0; i < nw; i++) begin
      if (i == rst_at) begin
        @(negedge Clk) Reset_n = 1'b0;
        @(negedge Clk) Reset_n = 1'b1;
      end
      bitp(lr, w[15-i]);
    end
    for (int i = 0; i < ntr; i++) bitp(lr, tv);
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int ntr, input logic tv);
    q0.push_back(l); q1.push_back(r);
    slot(1'b0, l, 16, ntr, tv, -1);
    slot(1'b1, r, 16, ntr, tv, -1);
  endtask

  // Downstream models: Done high 3 cycles after Start, low 1 cycle later.
  initial begin
    Done0 = 1'b0;
    forever begin
      @(negedge Clk);
      if (Start0 && !hold0) begin
        repeat (3) @(negedge Clk);
        Done0 = 1'b1;
        @(negedge Clk);
        Done0 = 1'b0;
      end
    end
  end

  initial begin
    Done1 = 1'b0;
    forever begin
      @(negedge Clk);
      if (Start1) begin
        repeat (3) @(negedge Clk);
        Done1 = 1'b1;
        @(negedge Clk);
        Done1 = 1'b0;
      end
    end
  end

  // Monitor: every rising Start pops the next expected word.
  initial begin
    logic s0q, s1q;
    s0q = 1'b0; s1q = 1'b0;
    forever begin
      @(negedge Clk);
      if (Start0 && !s0q) begin
        if (q0.size() == 0) check("unexpected_start_ch0", {16'h0, Sample0}, 32'hFFFF_FFFF);
        else                check("sample_ch0", {16'h0, Sample0}, {16'h0, q0.pop_front()});
      end
      if (Start1 && !s1q) begin
        if (q1.size() == 0) check("unexpected_start_ch1", {16'h0, Sample1}, 32'hFFFF_FFFF);
        else                check("sample_ch1", {16'h0, Sample1}, {16'h0, q1.pop_front()});
      end
      s0q = Start0; s1q = Start1;
      if (Overrun0) ov0++;
      if (Overrun1) ov1++;
    end
  end

  initial begin
    Reset_n = 1'b0; AUD_BCLK = 1'b0; AUD_ADCLRCK = 1'b0; AUD_ADCDAT = 1'b0;
    // Stream runs while reset is held.
    for (int i = 0; i < 4; i++) bitp(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) bitp(1'b0, 1'b1);
    check("reset_start0",  {31'h0, Start0}, 32'h0);
    check("reset_sample0", {16'h0, Sample0}, 32'h0);
    check("reset_start1",  {31'h0, Start1}, 32'h0);
    check("reset_sample1", {16'h0, Sample1}, 32'h0);
    check("reset_overrun", {31'h0, Overrun0}, 32'h0);
    Reset_n = 1'b1;
    bitp(1'b0, 1'b0); bitp(1'b0, 1'b0);

    // Lead-in right slot so the first left slot has a frame edge.
    q1.push_back(16'h0F0F);
    slot(1'b1, 16'h0F0F, 16, 1, 1'b0, -1);

    // First word, then handshake sequence.
    frame(16'hA5C3, 16'h1234, 1, 1'b0);
    frame(16'h0001, 16'h8000, 1, 1'b0);
    frame(16'h8000, 16'h7FFF, 1, 1'b0);
    frame(16'h7FFF, 16'hFFFF, 1, 1'b0);
    frame(16'hFFFF, 16'h0001, 1, 1'b0);
    check("no_overrun_handshake", ov0, 0);

    // 32-bit slots with trailing ones.
    frame(16'hBEEF, 16'hCAFE, 16, 1'b1);

    // Overrun: Done held low over two frames on channel 0.
    hold0 = 1'b1;
    frame(16'h1111, 16'h4444, 1, 1'b0);
    q0.push_back(16'h2222);
    void'(q0.pop_back());          // second left word is dropped
    q1.push_back(16'h5555);
    slot(1'b0, 16'h2222, 16, 1, 1'b0, -1);
    slot(1'b1, 16'h5555, 16, 1, 1'b0, -1);
    check("overrun_start_held", {31'h0, Start0}, 32'h1);
    check("overrun_sample_kept", {16'h0, Sample0}, 32'h1111);
    check("overrun_pulses", ov0, 1);
    hold0 = 1'b0;
    repeat (20) @(negedge Clk);
    check("overrun_start_cleared", {31'h0, Start0}, 32'h0);

    // Short frame: 9 bits then LRCK toggles.
    slot(1'b0, 16'hFFFF, 9, 0, 1'b0, -1);
    q1.push_back(16'h6666);
    slot(1'b1, 16'h6666, 16, 1, 1'b0, -1);
    frame(16'h5A5A, 16'hA5A5, 1, 1'b0);

    // Reset pulse during bit 7 of a left word.
    slot(1'b0, 16'h3C3C, 16, 1, 1'b0, 8);
    check("midreset_start0", {31'h0, Start0}, 32'h0);
    q1.push_back(16'h7777);
    slot(1'b1, 16'h7777, 16, 1, 1'b0, -1);
    frame(16'hC0DE, 16'hBEAD, 1, 1'b0);

    repeat (60) @(negedge Clk);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    check("overrun_total_ch0", ov0, 1);
    check("overrun_total_ch1", ov1, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
